// File: rtl/pipeline_control_unit_if.sv
// Handshake bundle between hazard/redirect sources and the pipeline
// control unit: requests in, stage enables, flushes and micro-ops out.
interface pipeline_control_unit_if #(
  parameter int CNT_W = 16
);
  logic             should_stall;
  logic             mem_busy;
  logic             branch_taken_ex;
  logic             jump_rr;
  logic             jump_id;
  logic             lmsm_start;
  logic [7:0]       lmsm_mask;
  logic             pc_we;
  logic             if_id_we;
  logic             id_rr_we;
  logic             rr_ex_we;
  logic             if_id_flush;
  logic             id_rr_flush;
  logic             rr_ex_flush;
  logic             uop_valid;
  logic [2:0]       uop_reg;
  logic [2:0]       uop_seq;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output should_stall, mem_busy, branch_taken_ex,
    output jump_rr, jump_id, lmsm_start, lmsm_mask,
    input  pc_we, if_id_we, id_rr_we, rr_ex_we,
    input  if_id_flush, id_rr_flush, rr_ex_flush,
    input  uop_valid, uop_reg, uop_seq,
    input  stall_cycles, flush_events
  );

  modport slave (
    input  should_stall, mem_busy, branch_taken_ex,
    input  jump_rr, jump_id, lmsm_start, lmsm_mask,
    output pc_we, if_id_we, id_rr_we, rr_ex_we,
    output if_id_flush, id_rr_flush, rr_ex_flush,
    output uop_valid, uop_reg, uop_seq,
    output stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_control_unit.sv
// Stall/flush/sequence controller for the six-stage pipeline with
// LM/SM micro-op sequencer and saturating event counters.
module pipeline_control_unit #(
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_control_unit_if.slave bus
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_LMSM = 1'b1
  } state_t;

  state_t           r_state, w_state_nx;
  logic [7:0]       r_mask, w_mask_nx;
  logic [2:0]       r_seq, w_seq_nx;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic       w_pc_we, w_if_id_we, w_id_rr_we, w_rr_ex_we;
  logic       w_if_id_fl, w_id_rr_fl, w_rr_ex_fl;
  logic       w_uop_valid, w_flush_evt;
  logic [2:0] w_uop_reg, w_uop_seq;
  logic [2:0] w_low_idx;
  logic       w_last;

  always_comb begin
    w_low_idx = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (r_mask[i]) w_low_idx = 3'(i);
  end

  assign w_last = (r_mask & (r_mask - 8'd1)) == 8'd0;

  always_comb begin
    w_state_nx  = r_state;
    w_mask_nx   = r_mask;
    w_seq_nx    = r_seq;
    w_pc_we     = 1'b1;
    w_if_id_we  = 1'b1;
    w_id_rr_we  = 1'b1;
    w_rr_ex_we  = 1'b1;
    w_if_id_fl  = 1'b0;
    w_id_rr_fl  = 1'b0;
    w_rr_ex_fl  = 1'b0;
    w_uop_valid = 1'b0;
    w_uop_reg   = 3'd0;
    w_uop_seq   = 3'd0;
    w_flush_evt = 1'b0;
    if (rst) begin
      w_state_nx = S_RUN;
      w_mask_nx  = 8'd0;
      w_seq_nx   = 3'd0;
      w_if_id_fl = 1'b1;
      w_id_rr_fl = 1'b1;
      w_rr_ex_fl = 1'b1;
    end else if (bus.mem_busy) begin
      // Freeze: a pending micro-op stays visible and is re-issued later.
      w_pc_we     = 1'b0;
      w_if_id_we  = 1'b0;
      w_id_rr_we  = 1'b0;
      w_rr_ex_we  = 1'b0;
      w_uop_valid = (r_state == S_LMSM);
      if (r_state == S_LMSM) begin
        w_uop_reg = w_low_idx;
        w_uop_seq = r_seq;
      end
    end else if (bus.branch_taken_ex) begin
      w_if_id_fl  = 1'b1;
      w_id_rr_fl  = 1'b1;
      w_rr_ex_fl  = 1'b1;
      w_flush_evt = 1'b1;
      w_state_nx  = S_RUN;
      w_mask_nx   = 8'd0;
      w_seq_nx    = 3'd0;
    end else if (bus.jump_rr) begin
      w_if_id_fl  = 1'b1;
      w_id_rr_fl  = 1'b1;
      w_flush_evt = 1'b1;
      w_state_nx  = S_RUN;
      w_mask_nx   = 8'd0;
      w_seq_nx    = 3'd0;
    end else if (r_state == S_LMSM) begin
      w_uop_valid = 1'b1;
      w_uop_reg   = w_low_idx;
      w_uop_seq   = r_seq;
      if (w_last) begin
        w_state_nx = S_RUN;
        w_mask_nx  = 8'd0;
        w_seq_nx   = 3'd0;
      end else begin
        w_pc_we    = 1'b0;
        w_if_id_we = 1'b0;
        w_mask_nx  = r_mask & ~(8'd1 << w_low_idx);
        w_seq_nx   = r_seq + 3'd1;
      end
    end else if (bus.should_stall) begin
      w_pc_we    = 1'b0;
      w_if_id_we = 1'b0;
      w_id_rr_fl = 1'b1;
    end else if (bus.jump_id) begin
      w_if_id_fl  = 1'b1;
      w_flush_evt = 1'b1;
    end else if (bus.lmsm_start && bus.lmsm_mask != 8'd0) begin
      // Entry cycle: the LM/SM itself is replaced by a bubble in RR.
      w_state_nx = S_LMSM;
      w_mask_nx  = bus.lmsm_mask;
      w_seq_nx   = 3'd0;
      w_pc_we    = 1'b0;
      w_if_id_we = 1'b0;
      w_id_rr_fl = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_mask  <= 8'd0;
      r_seq   <= 3'd0;
    end else begin
      r_state <= w_state_nx;
      r_mask  <= w_mask_nx;
      r_seq   <= w_seq_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_we && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (w_flush_evt && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.pc_we        = w_pc_we;
  assign bus.if_id_we     = w_if_id_we;
  assign bus.id_rr_we     = w_id_rr_we;
  assign bus.rr_ex_we     = w_rr_ex_we;
  assign bus.if_id_flush  = w_if_id_fl;
  assign bus.id_rr_flush  = w_id_rr_fl;
  assign bus.rr_ex_flush  = w_rr_ex_fl;
  assign bus.uop_valid    = w_uop_valid;
  assign bus.uop_reg      = w_uop_reg;
  assign bus.uop_seq      = w_uop_seq;
  assign bus.stall_cycles = r_stall_cnt;
  assign bus.flush_events = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit, built with 4-bit counters
// so saturation is reachable in a short run.
module tb_pipeline_control_unit;

  localparam int CW = 4;

  // ctl bit order: pc, if_id, id_rr, rr_ex we; if_id, id_rr, rr_ex flush
  localparam logic [6:0] C_DEF   = 7'b1111000;
  localparam logic [6:0] C_STALL = 7'b0011010;
  localparam logic [6:0] C_HOLD  = 7'b0011000;
  localparam logic [6:0] C_FRZ   = 7'b0000000;
  localparam logic [6:0] C_ALL   = 7'b1111111;
  localparam logic [6:0] C_JRR   = 7'b1111110;
  localparam logic [6:0] C_JID   = 7'b1111100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nerr = 0;

  pipeline_control_unit_if #(.CNT_W(CW)) bus ();

  pipeline_control_unit #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctl();
    return {bus.pc_we, bus.if_id_we, bus.id_rr_we, bus.rr_ex_we,
            bus.if_id_flush, bus.id_rr_flush, bus.rr_ex_flush};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_uop(input string tag, input logic v,
                         input logic [2:0] r, input logic [2:0] s);
    chk({tag, ".valid"}, 16'(bus.uop_valid), 16'(v));
    chk({tag, ".reg"}, 16'(bus.uop_reg), 16'(r));
    chk({tag, ".seq"}, 16'(bus.uop_seq), 16'(s));
  endtask

  task automatic drive(input logic ss, input logic mb, input logic bt,
                       input logic jr, input logic ji, input logic ls,
                       input logic [7:0] m);
    bus.should_stall    = ss;
    bus.mem_busy        = mb;
    bus.branch_taken_ex = bt;
    bus.jump_rr         = jr;
    bus.jump_id         = ji;
    bus.lmsm_start      = ls;
    bus.lmsm_mask       = m;
  endtask

  // Next cycle: wait for negedge, apply inputs, settle.
  task automatic cyc(input logic ss, input logic mb, input logic bt,
                     input logic jr, input logic ji, input logic ls,
                     input logic [7:0] m);
    @(negedge clk);
    drive(ss, mb, bt, jr, ji, ls, m);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    // Reset: forced outputs while rst is high.
    @(negedge clk);
    #1;
    chk("rst.ctl", 16'(ctl()), 16'(C_ALL));
    chk_uop("rst", 0, 0, 0);
    cyc(1, 0, 1, 0, 1, 1, 8'hFF);
    chk("rst.ctl_inputs", 16'(ctl()), 16'(C_ALL));
    chk_uop("rst_inputs", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    #1;
    chk("rst.stall_cnt", 16'(bus.stall_cycles), 16'd0);
    chk("rst.flush_cnt", 16'(bus.flush_events), 16'd0);
    chk("run.ctl", 16'(ctl()), 16'(C_DEF));

    // Load-use stall for one cycle.
    cyc(1, 0, 0, 0, 0, 0, 8'h00);
    chk("ld_use.ctl", 16'(ctl()), 16'(C_STALL));
    idle();
    chk("ld_use.after", 16'(ctl()), 16'(C_DEF));
    chk("ld_use.stall_cnt", 16'(bus.stall_cycles), 16'd1);

    // LM with mask 1010_0100.
    do_reset();
    cyc(0, 0, 0, 0, 0, 1, 8'hA4);
    chk("lm.entry.ctl", 16'(ctl()), 16'(C_STALL));
    chk_uop("lm.entry", 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 8'hA4);
    chk("lm.u0.ctl", 16'(ctl()), 16'(C_HOLD));
    chk_uop("lm.u0", 1, 2, 0);
    idle();
    chk("lm.u1.ctl", 16'(ctl()), 16'(C_HOLD));
    chk_uop("lm.u1", 1, 5, 1);
    idle();
    chk("lm.u2.ctl", 16'(ctl()), 16'(C_DEF));
    chk_uop("lm.u2", 1, 7, 2);
    idle();
    chk_uop("lm.done", 0, 0, 0);
    chk("lm.done.ctl", 16'(ctl()), 16'(C_DEF));
    chk("lm.stall_cnt", 16'(bus.stall_cycles), 16'd3);

    // Zero mask LM/SM behaves as a NOP.
    cyc(0, 0, 0, 0, 0, 1, 8'h00);
    chk("nop.ctl", 16'(ctl()), 16'(C_DEF));
    idle();
    chk_uop("nop.after", 0, 0, 0);
    chk("nop.stall_cnt", 16'(bus.stall_cycles), 16'd3);

    // Branch aborts LMSM on second micro-op.
    do_reset();
    cyc(0, 0, 0, 0, 0, 1, 8'h0F);
    idle();
    chk_uop("br.u0", 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 8'h00);
    chk("br.ctl", 16'(ctl()), 16'(C_ALL));
    chk_uop("br.u1", 0, 0, 0);
    idle();
    chk("br.after.ctl", 16'(ctl()), 16'(C_DEF));
    chk_uop("br.after", 0, 0, 0);
    chk("br.flush_cnt", 16'(bus.flush_events), 16'd1);

    // Simultaneous stall, JAL and branch: branch wins.
    do_reset();
    cyc(1, 0, 1, 0, 1, 0, 8'h00);
    chk("prio.ctl", 16'(ctl()), 16'(C_ALL));
    idle();
    chk("prio.flush_cnt", 16'(bus.flush_events), 16'd1);
    chk("prio.stall_cnt", 16'(bus.stall_cycles), 16'd0);

    // jump_rr beats should_stall; jump_id alone.
    cyc(1, 0, 0, 1, 0, 0, 8'h00);
    chk("jrr.ctl", 16'(ctl()), 16'(C_JRR));
    cyc(0, 0, 0, 0, 1, 1, 8'h0F);
    chk("jid.ctl", 16'(ctl()), 16'(C_JID));
    idle();
    chk_uop("jid.after", 0, 0, 0);
    chk("jid.flush_cnt", 16'(bus.flush_events), 16'd3);

    // mem_busy freezes LMSM for three cycles at uop_reg 0.
    do_reset();
    cyc(0, 0, 0, 0, 0, 1, 8'h03);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0, 1, 0, 8'h00);
      chk("mb.ctl", 16'(ctl()), 16'(C_FRZ));
      chk("mb.reg", 16'(bus.uop_reg), 16'd0);
      chk("mb.seq", 16'(bus.uop_seq), 16'd0);
    end
    idle();
    chk("mb.u0.ctl", 16'(ctl()), 16'(C_HOLD));
    chk_uop("mb.u0", 1, 0, 0);
    idle();
    chk("mb.u1.ctl", 16'(ctl()), 16'(C_DEF));
    chk_uop("mb.u1", 1, 1, 1);
    idle();
    chk_uop("mb.done", 0, 0, 0);
    chk("mb.stall_cnt", 16'(bus.stall_cycles), 16'd5);
    chk("mb.flush_cnt", 16'(bus.flush_events), 16'd0);

    // Full mask: eight micro-ops, seq 0..7.
    do_reset();
    cyc(0, 0, 0, 0, 0, 1, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      idle();
      chk_uop("full", 1, 3'(i), 3'(i));
      chk("full.pc_we", 16'(bus.pc_we), 16'(i == 7));
    end
    idle();
    chk_uop("full.done", 0, 0, 0);
    chk("full.stall_cnt", 16'(bus.stall_cycles), 16'd8);

    // Saturation, then reset mid-LMSM.
    do_reset();
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0, 0, 8'h00);
    idle();
    chk("sat.stall_cnt", 16'(bus.stall_cycles), 16'hF);
    cyc(1, 0, 0, 0, 0, 0, 8'h00);
    idle();
    chk("sat.hold", 16'(bus.stall_cycles), 16'hF);
    cyc(0, 0, 0, 0, 1, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 1, 8'h0F);
    idle();
    chk("mid.flush_cnt", 16'(bus.flush_events), 16'd1);
    chk_uop("mid.u0", 1, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid.rst.ctl", 16'(ctl()), 16'(C_ALL));
    chk_uop("mid.rst", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid.stall_cnt", 16'(bus.stall_cycles), 16'd0);
    chk("mid.flush_cnt0", 16'(bus.flush_events), 16'd0);
    chk("mid.ctl", 16'(ctl()), 16'(C_DEF));
    chk_uop("mid.after", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
